// File: rtl/morse_pkg.sv
// Shared Morse decoder definitions: FSM states, ASCII constants and the
// (length, code) -> character table. Dot = 1, dash = 0, first symbol is the MSB.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    OVERFLOW = 2'd2
  } state_e;

  localparam logic [7:0] CHAR_UNDEF = 8'h3F;
  localparam logic [7:0] CHAR_A     = 8'h41;
  localparam logic [7:0] CHAR_0     = 8'h30;

  localparam int MAX_DEFINED_LEN = 5;

  typedef struct packed {
    logic       valid;
    logic [7:0] ch;
  } lookup_t;

  // Code bits above len must already be zero; the key is {len, code}.
  function automatic lookup_t morse_lookup(input logic [2:0] len, input logic [4:0] code);
    lookup_t r;
    r.valid = 1'b1;
    r.ch    = CHAR_UNDEF;
    case ({len, code})
      {3'd1, 5'b00000}: r.ch = CHAR_A + 8'd19;
      {3'd1, 5'b00001}: r.ch = CHAR_A + 8'd4;
      {3'd2, 5'b00000}: r.ch = CHAR_A + 8'd12;
      {3'd2, 5'b00001}: r.ch = CHAR_A + 8'd13;
      {3'd2, 5'b00010}: r.ch = CHAR_A + 8'd0;
      {3'd2, 5'b00011}: r.ch = CHAR_A + 8'd8;
      {3'd3, 5'b00000}: r.ch = CHAR_A + 8'd14;
      {3'd3, 5'b00001}: r.ch = CHAR_A + 8'd6;
      {3'd3, 5'b00010}: r.ch = CHAR_A + 8'd10;
      {3'd3, 5'b00011}: r.ch = CHAR_A + 8'd3;
      {3'd3, 5'b00100}: r.ch = CHAR_A + 8'd22;
      {3'd3, 5'b00101}: r.ch = CHAR_A + 8'd17;
      {3'd3, 5'b00110}: r.ch = CHAR_A + 8'd20;
      {3'd3, 5'b00111}: r.ch = CHAR_A + 8'd18;
      {3'd4, 5'b00010}: r.ch = CHAR_A + 8'd16;
      {3'd4, 5'b00011}: r.ch = CHAR_A + 8'd25;
      {3'd4, 5'b00100}: r.ch = CHAR_A + 8'd24;
      {3'd4, 5'b00101}: r.ch = CHAR_A + 8'd2;
      {3'd4, 5'b00110}: r.ch = CHAR_A + 8'd23;
      {3'd4, 5'b00111}: r.ch = CHAR_A + 8'd1;
      {3'd4, 5'b01000}: r.ch = CHAR_A + 8'd9;
      {3'd4, 5'b01001}: r.ch = CHAR_A + 8'd15;
      {3'd4, 5'b01011}: r.ch = CHAR_A + 8'd11;
      {3'd4, 5'b01101}: r.ch = CHAR_A + 8'd5;
      {3'd4, 5'b01110}: r.ch = CHAR_A + 8'd21;
      {3'd4, 5'b01111}: r.ch = CHAR_A + 8'd7;
      {3'd5, 5'b00000}: r.ch = CHAR_0 + 8'd0;
      {3'd5, 5'b10000}: r.ch = CHAR_0 + 8'd1;
      {3'd5, 5'b11000}: r.ch = CHAR_0 + 8'd2;
      {3'd5, 5'b11100}: r.ch = CHAR_0 + 8'd3;
      {3'd5, 5'b11110}: r.ch = CHAR_0 + 8'd4;
      {3'd5, 5'b11111}: r.ch = CHAR_0 + 8'd5;
      {3'd5, 5'b01111}: r.ch = CHAR_0 + 8'd6;
      {3'd5, 5'b00111}: r.ch = CHAR_0 + 8'd7;
      {3'd5, 5'b00011}: r.ch = CHAR_0 + 8'd8;
      {3'd5, 5'b00001}: r.ch = CHAR_0 + 8'd9;
      default:          r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/morse_rom.sv
// Combinational (len, code) -> {valid, char} lookup; anything longer than
// five symbols is undefined.
import morse_pkg::*;

module morse_rom #(
  parameter int MAX_LEN = 5,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic [LEN_W-1:0]   len_i,
  input  logic [MAX_LEN-1:0] code_i,
  output logic               valid_o,
  output logic [7:0]         char_o
);

  logic [5:0] mask;
  lookup_t    hit;

  always_comb begin
    mask = (6'd1 << len_i) - 6'd1;
    hit  = morse_lookup(len_i[2:0], code_i[4:0] & mask[4:0]);
    if (len_i > LEN_W'(MAX_DEFINED_LEN)) begin
      hit.valid = 1'b0;
    end
    valid_o = hit.valid;
    char_o  = hit.valid ? hit.ch : CHAR_UNDEF;
  end

endmodule

// File: rtl/morse_decoder.sv
// Morse symbol collector: shifts dots/dashes into a code register and, on a
// gap strobe, emits the decoded ASCII character or an error pulse.
import morse_pkg::*;

module morse_decoder #(
  parameter int MAX_LEN = 5,
  parameter int CHAR_W  = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           sym_valid,
  input  logic                           sym,
  input  logic                           gap,
  output logic [CHAR_W-1:0]              out,
  output logic                           out_valid,
  output logic                           err,
  output logic                           busy,
  output logic [$clog2(MAX_LEN+1)-1:0]   len
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  state_e             state_q, state_d, acc_state;
  logic [MAX_LEN-1:0] code_q, code_d, acc_code;
  logic [LEN_W-1:0]   len_q, len_d, acc_len;
  logic [CHAR_W-1:0]  out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic               err_q, err_d;
  logic               rom_valid;
  logic [7:0]         rom_char;

  // A symbol arriving with a gap is accepted first so the lookup sees it.
  always_comb begin
    acc_state = state_q;
    acc_code  = code_q;
    acc_len   = len_q;
    if (sym_valid && state_q != OVERFLOW) begin
      if (len_q < LEN_W'(MAX_LEN)) begin
        acc_code  = {code_q[MAX_LEN-2:0], sym};
        acc_len   = len_q + LEN_W'(1);
        acc_state = COLLECT;
      end else begin
        acc_state = OVERFLOW;
      end
    end
  end

  morse_rom #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_rom (
    .len_i   (acc_len),
    .code_i  (acc_code),
    .valid_o (rom_valid),
    .char_o  (rom_char)
  );

  always_comb begin
    state_d     = acc_state;
    code_d      = acc_code;
    len_d       = acc_len;
    out_d       = out_q;
    out_valid_d = 1'b0;
    err_d       = 1'b0;
    if (gap && acc_state != IDLE) begin
      if (acc_state == COLLECT && rom_valid) begin
        out_d       = CHAR_W'(rom_char);
        out_valid_d = 1'b1;
      end else begin
        out_d = CHAR_W'(CHAR_UNDEF);
        err_d = 1'b1;
      end
      state_d = IDLE;
      code_d  = '0;
      len_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      code_q      <= '0;
      len_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      len_q       <= len_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);
  assign len       = len_q;

endmodule

// File: doc/morse_decoder.md
MORSE_DECODER -- requirements
Module: morse_decoder

Interface
REQ-001 SHALL have parameter MAX_LEN, default 5, meaning maximum symbols per character (legal range 5..8).
REQ-002 SHALL have parameter CHAR_W, default 8, meaning output character width (ASCII).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning reset; reset is asynchronous and active-high.
REQ-005 SHALL have port sym_valid  input  1  meaning sym carries a new symbol this cycle.
REQ-006 SHALL have port sym  input  1  meaning symbol value: 1 = dot, 0 = dash.
REQ-007 SHALL have port gap  input  1  meaning a one-cycle strobe that closes the current character.
REQ-008 SHALL have port out  output  CHAR_W  meaning last decoded character, held between updates.
REQ-009 SHALL have port out_valid  output  1  meaning a one-cycle pulse when out updates with a valid character.
REQ-010 SHALL have port err  output  1  meaning a one-cycle pulse when a closed character is undefined or overflowed.
REQ-011 SHALL have port busy  output  1  meaning high while at least one symbol is collected and not yet closed.
REQ-012 SHALL have port len  output  $clog2(MAX_LEN+1)  meaning count of symbols collected so far.

Function
REQ-013 SHALL implement states IDLE, COLLECT and OVERFLOW.
REQ-014 SHALL hold symbols in a MAX_LEN-bit code register, shifted left with each new symbol entering the LSB, so the first symbol is the MSB of the low len bits.
REQ-015 SHALL, on sym_valid in IDLE or COLLECT with len < MAX_LEN, shift the symbol in, increment len and go to COLLECT.
REQ-016 SHALL, on sym_valid in COLLECT with len == MAX_LEN, go to OVERFLOW with code and len frozen.
REQ-017 SHALL ignore sym_valid in OVERFLOW.
REQ-018 SHALL, on gap in COLLECT, look up (len, code): a defined code loads its ASCII value into out and pulses out_valid; an undefined code loads 8'h3F ('?') into out and pulses err.
REQ-019 SHALL, on gap in OVERFLOW, load 8'h3F into out and pulse err.
REQ-020 SHALL clear code and len and return to IDLE on every gap accepted in COLLECT or OVERFLOW.
REQ-021 SHALL ignore gap in IDLE when sym_valid is low: no pulse, and out is unchanged.
REQ-022 SHALL treat sym_valid and gap in the same cycle as symbol first, then close; the appended symbol is included in the lookup, and overflow applies if len was already MAX_LEN.
REQ-023 SHALL register out, out_valid and err, so they appear exactly one cycle after the closing gap edge.
REQ-024 SHALL never assert out_valid and err in the same cycle.
REQ-025 SHALL decode A-Z (8'h41-8'h5A) and digits 0-9 (8'h30-8'h39) using the international Morse codes.
REQ-026 SHALL treat every other (len, code) pair, including all codes longer than 5 symbols, as undefined.
REQ-027 SHALL allow back-to-back characters: a symbol in the cycle after a gap starts a new character with no lost cycle.

Reset
REQ-028 SHALL, on reset assertion, immediately force state=IDLE, code=0, len=0, out=8'h00, out_valid=0, err=0 and busy=0, independent of clk.
REQ-029 SHALL discard any partial character when reset is asserted mid-collection, with no pulse.
REQ-030 SHALL resume normal operation on the first clk edge after reset deasserts.

Structure
REQ-031 SHALL place the state encoding, the ASCII constants ('?', 'A', '0') and the lookup table contents in shared package morse_pkg.
REQ-032 SHALL implement the (len, code) to {valid, char} lookup as combinational sub-module morse_rom, instanced once.

Verification
REQ-033 SHALL verify: sym 1,0 then gap -> one cycle later out=8'h41, out_valid=1 for 1 cycle, err=0.
REQ-034 SHALL verify: five dashes then gap -> out=8'h30; then 1,0,0,0,0 then gap -> out=8'h31, back-to-back with no idle cycle.
REQ-035 SHALL verify: six symbols then gap -> err=1 for 1 cycle, out=8'h3F, len returns to 0.
REQ-036 SHALL verify: 1,1,0,0 then gap (undefined) -> err=1, out=8'h3F; a lone gap in IDLE -> no pulse, out unchanged.
REQ-037 SHALL verify: sym_valid=1, sym=0 and gap in one cycle from IDLE -> out=8'h54 ('T').
REQ-038 SHALL verify: reset asserted after 3 symbols -> len=0, busy=0 and out=8'h00 asynchronously; a following gap produces no pulse.
